// File: rtl/memory_f1_up_3_ctl.sv
// -----------------------------------------------------------------------------
// memory_f1_up_3_ctl
//
// Access controller for long tank 3 of the upper F1 memory bank. A pair of
// free-running counters tracks which pulse position (minor, digit) is
// currently passing the tank's read/write head. On an accepted request the
// controller waits for the addressed slot to come round, then gates one short
// (18-position) or long (36-position) word into or out of the tank. Data is
// serial, LSB first, and the last position of the word is the gap.
//
// Optional build feature: define MEMORY_F1_UP_3_CTL_TIMING_OUT_EN to export
// the position counters (pos_minor, pos_digit) and a (0,0) sync pulse
// (pos_sync) for the monitor display and sibling tanks.
//
// Ports:
//   f1_clk        in   digit clock, one pulse position per cycle
//   f1_rst_n      in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  controller idle; accept = req_valid && req_ready
//   req_addr      in   short-word slot 0..MINORS-1
//   req_long      in   long word (slots addr&~1 and addr|1)
//   req_op        in   0 read, 1 write, 2 clear, 3 reserved (read)
//   wr_data       in   write data, captured on accept
//   rd_data       out  read result, valid from done, held until next read
//   done          out  one-cycle end-of-transfer pulse
//   f1_mib        out  serial write bit to the tank
//   f1_up_t3_in   out  tank write gate
//   f1_up_t3_out  out  tank read gate
//   f1_up_t3_clr  out  tank clear gate
//   f1_up_mob_t3  in   serial output bit from the tank
//   pos_minor     out  (optional) current minor cycle
//   pos_digit     out  (optional) current digit
//   pos_sync      out  (optional) one-cycle pulse at position (0,0)
// -----------------------------------------------------------------------------
module memory_f1_up_3_ctl #(
  parameter int DIGITS = 18,
  parameter int MINORS = 32
) (
  input  logic                  f1_clk,
  input  logic                  f1_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_addr,
  input  logic                  req_long,
  input  logic [1:0]            req_op,
  input  logic [2*DIGITS-2:0]   wr_data,
  output logic [2*DIGITS-2:0]   rd_data,
  output logic                  done,
  output logic                  f1_mib,
  output logic                  f1_up_t3_in,
  output logic                  f1_up_t3_out,
  output logic                  f1_up_t3_clr,
  input  logic                  f1_up_mob_t3
`ifdef MEMORY_F1_UP_3_CTL_TIMING_OUT_EN
  ,
  output logic [4:0]            pos_minor,
  output logic [4:0]            pos_digit,
  output logic                  pos_sync
`endif
);

  localparam int WB = 2 * DIGITS - 1;       // long word data bits
  localparam int KW = $clog2(2 * DIGITS);   // transfer index width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------------------
  logic [4:0] digit_q, digit_d;
  logic [4:0] minor_q, minor_d;
  logic       digit_wrap;

  always_comb begin
    digit_wrap = (digit_q == 5'(DIGITS - 1));
    digit_d    = digit_wrap ? 5'd0 : digit_q + 5'd1;
    minor_d    = minor_q;
    if (digit_wrap) begin
      minor_d = (minor_q == 5'(MINORS - 1)) ? 5'd0 : minor_q + 5'd1;
    end
  end

  always_ff @(posedge f1_clk or negedge f1_rst_n) begin
    if (!f1_rst_n) begin
      digit_q <= 5'd0;
      minor_q <= 5'd0;
    end else begin
      digit_q <= digit_d;
      minor_q <= minor_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [4:0]      addr_q, addr_d;
  logic            long_q, long_d;
  logic [1:0]      op_q, op_d;
  logic [WB-1:0]   wdata_q, wdata_d;
  logic [KW-1:0]   k_q, k_d;

  logic            accept;
  logic [4:0]      req_addr_eff;

  // While idle, a request can go straight to XFER (accept one position before
  // the slot), so the "active" transfer parameters come from the request
  // inputs in IDLE and from the captured copies everywhere else.
  logic [4:0]      act_addr;
  logic            act_long;
  logic [1:0]      act_op;
  logic [WB-1:0]   act_wdata;
  logic [KW-1:0]   last_k;
  logic            slot_hit;
  logic            act_write;
  logic            act_clear;
  logic            act_read;

  always_comb begin
    accept       = (state_q == ST_IDLE) && req_valid;
    req_addr_eff = req_long ? {req_addr[4:1], 1'b0} : req_addr;

    act_addr  = accept ? req_addr_eff : addr_q;
    act_long  = accept ? req_long     : long_q;
    act_op    = accept ? req_op       : op_q;
    act_wdata = accept ? wr_data      : wdata_q;

    last_k    = act_long ? KW'(2 * DIGITS - 1) : KW'(DIGITS - 1);
    act_write = (act_op == 2'd1);
    act_clear = (act_op == 2'd2);
    act_read  = !act_write && !act_clear;

    // Next-cycle position equals (act_addr, 0).
    slot_hit  = digit_wrap && (minor_d == act_addr);

    addr_d  = addr_q;
    long_d  = long_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    if (accept) begin
      addr_d  = req_addr_eff;
      long_d  = req_long;
      op_d    = req_op;
      wdata_d = wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = slot_hit ? ST_XFER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (slot_hit) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (k_q == last_k) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    k_d = '0;
    if (state_d == ST_XFER && state_q == ST_XFER) begin
      k_d = k_q + KW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Gate outputs, registered from the next state so that they line up with
  // the slot position with no skew between f1_mib and the gates.
  // ---------------------------------------------------------------------------
  logic            mib_q, mib_d;
  logic            in_q, in_d;
  logic            out_q, out_d;
  logic            clr_q, clr_d;
  logic [WB:0]     wdata_ext;
  logic            xfer_d;

  always_comb begin
    wdata_ext = {1'b0, act_wdata};
    xfer_d    = (state_d == ST_XFER);
    in_d      = xfer_d && act_write;
    clr_d     = xfer_d && (act_write || act_clear);
    out_d     = xfer_d && act_read;
    // The gap position (k == last_k) always writes 0.
    mib_d     = xfer_d && act_write && (k_d < last_k) && wdata_ext[k_d];
  end

  // ---------------------------------------------------------------------------
  // Read capture: bit k of the word is sampled while position k passes.
  // ---------------------------------------------------------------------------
  logic [WB-1:0] rd_q, rd_d;
  logic [WB-1:0] rd_hit;
  logic          rd_sample;

  assign rd_sample = (state_q == ST_XFER) && (op_q != 2'd1) && (op_q != 2'd2)
                     && (k_q < last_k);

  for (genvar gi = 0; gi < WB; gi++) begin : g_rd_hit
    assign rd_hit[gi] = rd_sample && (k_q == KW'(gi));
  end

  always_comb begin
    rd_d = rd_q;
    // Clearing on accept keeps the unused upper bits of a short read at zero.
    if (accept && (req_op != 2'd1) && (req_op != 2'd2)) begin
      rd_d = '0;
    end
    rd_d = (rd_d & ~rd_hit) | ({WB{f1_up_mob_t3}} & rd_hit);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge f1_clk or negedge f1_rst_n) begin
    if (!f1_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 5'd0;
      long_q  <= 1'b0;
      op_q    <= 2'd0;
      wdata_q <= '0;
      k_q     <= '0;
      rd_q    <= '0;
      mib_q   <= 1'b0;
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      long_q  <= long_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      mib_q   <= mib_d;
      in_q    <= in_d;
      out_q   <= out_d;
      clr_q   <= clr_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign rd_data      = rd_q;
  assign f1_mib       = mib_q;
  assign f1_up_t3_in  = in_q;
  assign f1_up_t3_out = out_q;
  assign f1_up_t3_clr = clr_q;

`ifdef MEMORY_F1_UP_3_CTL_TIMING_OUT_EN
  // Registered so that it stays 0 during reset and pulses for exactly the
  // cycle in which the counters read (0, 0).
  logic sync_q, sync_d;

  assign sync_d = digit_wrap && (minor_d == 5'd0);

  always_ff @(posedge f1_clk or negedge f1_rst_n) begin
    if (!f1_rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pos_minor = minor_q;
  assign pos_digit = digit_q;
  assign pos_sync  = sync_q;
`endif

endmodule

// File: tb/tb_memory_f1_up_3_ctl.sv
module tb_memory_f1_up_3_ctl;

  localparam int DIG = 18;
  localparam int PER = 576;

  logic        f1_clk = 1'b0;
  logic        f1_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_addr = 5'd0;
  logic        req_long = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [34:0] wr_data = 35'd0;
  logic [34:0] rd_data;
  logic        done;
  logic        f1_mib;
  logic        t3_in;
  logic        t3_out;
  logic        t3_clr;
  logic        mob;
`ifdef MEMORY_F1_UP_3_CTL_TIMING_OUT_EN
  logic [4:0]  pos_minor;
  logic [4:0]  pos_digit;
  logic        pos_sync;
`endif

  int n_vec = 0;
  int n_miss = 0;

  memory_f1_up_3_ctl dut (
    .f1_clk       (f1_clk),
    .f1_rst_n     (f1_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_long     (req_long),
    .req_op       (req_op),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .done         (done),
    .f1_mib       (f1_mib),
    .f1_up_t3_in  (t3_in),
    .f1_up_t3_out (t3_out),
    .f1_up_t3_clr (t3_clr),
    .f1_up_mob_t3 (mob)
`ifdef MEMORY_F1_UP_3_CTL_TIMING_OUT_EN
    ,
    .pos_minor    (pos_minor),
    .pos_digit    (pos_digit),
    .pos_sync     (pos_sync)
`endif
  );

  always #5 f1_clk = ~f1_clk;

  // Tank model: a 576-position circulating delay line with the head at 'pos'.
  bit tank [PER];
  int pos = 0;

  always @(posedge f1_clk or negedge f1_rst_n) begin
    if (!f1_rst_n) pos <= 0;
    else           pos <= (pos == PER - 1) ? 0 : pos + 1;
  end

  always @(posedge f1_clk) begin
    if (f1_rst_n) begin
      if (t3_in)       tank[pos] <= f1_mib;
      else if (t3_clr) tank[pos] <= 1'b0;
    end
  end

  assign mob = tank[pos];

  typedef struct {
    logic [4:0]  addr;
    logic        lng;
    logic [1:0]  op;
    logic [34:0] data;
    int          at_pos;   // -1: accept whenever idle
    int          exp_lat;  // -1: no fixed latency expectation
    logic [34:0] exp_rd;
  } vec_t;

  vec_t        vecs [21];
  logic [34:0] sb_q [$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int eff, len, acc_pos, exp_lat, cyc, first_cyc, done_cyc, mix, j, waited;
    bit is_rd;
    logic e_in, e_out, e_clr, e_mib;
    logic [34:0] exp_rd;
    eff   = v.lng ? int'(v.addr & 5'h1E) : int'(v.addr);
    len   = v.lng ? 2 * DIG : DIG;
    is_rd = (v.op == 2'd0) || (v.op == 2'd3);

    @(negedge f1_clk);
    waited = 0;
    while (!req_ready && waited < 1000) begin
      @(negedge f1_clk);
      waited++;
    end
    check("ready_wait", req_ready, 1);
    if (v.at_pos >= 0) begin
      waited = 0;
      while (pos != v.at_pos && waited < 600) begin
        @(negedge f1_clk);
        waited++;
      end
      check("pos_wait", pos, v.at_pos);
    end

    req_valid = 1'b1;
    req_addr  = v.addr;
    req_long  = v.lng;
    req_op    = v.op;
    wr_data   = v.data;
    acc_pos   = pos;
    if (is_rd) sb_q.push_back(v.exp_rd);
    exp_lat = ((((eff * DIG - acc_pos - 1) % PER) + PER) % PER) + 1;

    // req_valid stays high through the transfer; it must not be re-accepted.
    cyc = 0; first_cyc = -1; done_cyc = -1; mix = 0;
    while (done_cyc < 0 && cyc < 700) begin
      @(negedge f1_clk);
      cyc++;
      j = cyc - exp_lat;
      if (first_cyc < 0 && (t3_in || t3_out || t3_clr || f1_mib)) first_cyc = cyc;
      e_in = 1'b0; e_out = 1'b0; e_clr = 1'b0; e_mib = 1'b0;
      if (j >= 0 && j < len) begin
        if (v.op == 2'd1) begin
          e_in = 1'b1; e_clr = 1'b1;
          e_mib = (j < len - 1) ? v.data[j] : 1'b0;
        end else if (v.op == 2'd2) begin
          e_clr = 1'b1;
        end else begin
          e_out = 1'b1;
        end
      end
      if ({t3_in, t3_out, t3_clr, f1_mib} !== {e_in, e_out, e_clr, e_mib}) mix++;
      if (done === 1'b1) done_cyc = cyc;
    end
    req_valid = 1'b0;

    check("first_gate", first_cyc, exp_lat);
    check("gate_pattern", mix, 0);
    check("done_cycle", done_cyc, exp_lat + len);
    if (v.exp_lat >= 0) check("latency", first_cyc, v.exp_lat);
    if (is_rd && sb_q.size() > 0) begin
      exp_rd = sb_q.pop_front();
      check("rd_data", rd_data, exp_rd);
    end
    @(negedge f1_clk);
    check("ready_after_done", {req_ready, done}, 2'b10);
    $display("txn %0d: op=%0d addr=%0d long=%0d accept_pos=%0d latency=%0d rd_data=0x%0h",
             idx, v.op, v.addr, v.lng, acc_pos, first_cyc, rd_data);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol, cnt, cyc, dn;
    vec_t rv;

    //           addr    lng   op    data              at_pos exp_lat exp_rd
    vecs[0]  = '{5'd5,  1'b0, 2'd1, 35'h1ABCD,        -1,    -1,     35'h0};
    vecs[1]  = '{5'd5,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h1ABCD};
    vecs[2]  = '{5'd31, 1'b1, 2'd1, 35'h5_5555_5555,  -1,    -1,     35'h0};
    vecs[3]  = '{5'd30, 1'b1, 2'd0, 35'h0,            -1,    -1,     35'h5_5555_5555};
    vecs[4]  = '{5'd6,  1'b0, 2'd1, 35'h00123,        -1,    -1,     35'h0};
    vecs[5]  = '{5'd8,  1'b0, 2'd1, 35'h1F0F0,        -1,    -1,     35'h0};
    vecs[6]  = '{5'd7,  1'b0, 2'd1, 35'h1FFFF,        -1,    -1,     35'h0};
    vecs[7]  = '{5'd7,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h1FFFF};
    vecs[8]  = '{5'd7,  1'b0, 2'd2, 35'h0,            -1,    -1,     35'h0};
    vecs[9]  = '{5'd7,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h0};
    vecs[10] = '{5'd6,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h00123};
    vecs[11] = '{5'd8,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h1F0F0};
    vecs[12] = '{5'd5,  1'b0, 2'd3, 35'h0,            -1,    -1,     35'h1ABCD};
    vecs[13] = '{5'd0,  1'b0, 2'd1, 35'h7_FFFF_FFFF,  -1,    -1,     35'h0};
    vecs[14] = '{5'd0,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h1FFFF};
    vecs[15] = '{5'd31, 1'b1, 2'd0, 35'h0,            -1,    -1,     35'h5_5555_5555};
    vecs[16] = '{5'd4,  1'b0, 2'd0, 35'h0,            71,    1,      35'h0};
    vecs[17] = '{5'd4,  1'b0, 2'd0, 35'h0,            72,    576,    35'h0};
    vecs[18] = '{5'd12, 1'b1, 2'd1, 35'h2_AAAA_AAAA,  -1,    -1,     35'h0};
    vecs[19] = '{5'd13, 1'b1, 2'd0, 35'h0,            -1,    -1,     35'h2_AAAA_AAAA};
    vecs[20] = '{5'd5,  1'b0, 2'd0, 35'h0,            -1,    -1,     35'h1ABCD};

    for (int i = 0; i < PER; i++) tank[i] = 1'b0;

    // Reset state and a full idle circulation.
    repeat (3) @(negedge f1_clk);
    check("reset_outputs", {req_ready, done, t3_in, t3_out, t3_clr, f1_mib}, 6'b100000);
    check("reset_rd_data", rd_data, 0);
    f1_rst_n = 1'b1;
    viol = 0;
    repeat (PER) begin
      @(negedge f1_clk);
      if ({t3_in, t3_out, t3_clr, f1_mib, done} !== 5'b0 || req_ready !== 1'b1) viol++;
    end
    check("idle_quiet", viol, 0);

    for (int i = 0; i < 21; i++) run_txn(vecs[i], i);

    // Reset while bit k = 9 of a write is on the tank.
    @(negedge f1_clk);
    cyc = 0;
    while (!req_ready && cyc < 1000) begin
      @(negedge f1_clk);
      cyc++;
    end
    req_valid = 1'b1; req_addr = 5'd10; req_long = 1'b0; req_op = 2'd1; wr_data = 35'h15555;
    cnt = 0; cyc = 0;
    while (cnt < 10 && cyc < 700) begin
      @(negedge f1_clk);
      cyc++;
      if (t3_in) cnt++;
    end
    check("abort_reached_k9", cnt, 10);
    f1_rst_n = 1'b0;
    #1;
    check("abort_gates", {t3_in, t3_out, t3_clr, f1_mib, done}, 5'b0);
    check("abort_ready", req_ready, 1);
    check("abort_rd_data", rd_data, 0);
    req_valid = 1'b0;
    dn = 0;
    repeat (3) begin
      @(negedge f1_clk);
      if (done) dn++;
    end
    f1_rst_n = 1'b1;
    repeat (40) begin
      @(negedge f1_clk);
      if ({t3_in, t3_out, t3_clr, f1_mib, done} !== 5'b0 || req_ready !== 1'b1) dn++;
    end
    check("abort_quiet", dn, 0);
    $display("txn abort: write slot 10 reset at k=9, quiet cycles checked");

    // Recovery after the aborted transfer.
    rv = '{5'd5, 1'b0, 2'd0, 35'h0, -1, -1, 35'h1ABCD};
    run_txn(rv, 21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
